// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and shifts it out one registered bit per clock with bit-valid and last flags.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_sd,
    output logic             o_sv,
    output logic             o_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] sr;
    logic             accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // A new word may land on the same edge that retires the last bit of the current one.
    assign o_ready = !i_rst && ((state == IDLE) || (cnt == LAST_CNT));
    assign accept  = i_valid && o_ready;
    assign cnt_nxt = cnt + CW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sr     <= '0;
            o_sd   <= 1'b0;
            o_sv   <= 1'b0;
            o_last <= 1'b0;
        end else if (accept) begin
            state  <= SHIFT;
            cnt    <= '0;
            sr     <= advance(i_data);
            o_sd   <= first_bit(i_data);
            o_sv   <= 1'b1;
            o_last <= 1'b0;
        end else if (state == SHIFT) begin
            if (cnt == LAST_CNT) begin
                state  <= IDLE;
                cnt    <= '0;
                sr     <= '0;
                o_sd   <= 1'b0;
                o_sv   <= 1'b0;
                o_last <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                sr     <= advance(sr);
                o_sd   <= first_bit(sr);
                o_last <= (cnt_nxt == LAST_CNT);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an LSB-first and an MSB-first instance
// share stimulus, and each cycle's outputs are compared to hand-computed rows.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       rdy_l, sd_l, sv_l, last_l;
    logic       rdy_m, sd_m, sv_m, last_m;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       sd;
        logic       sd_msb;
        logic       sv;
        logic       last;
        logic       rdy;
    } row_t;

    row_t rows[$];

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(rdy_l), .o_sd(sd_l), .o_sv(sv_l), .o_last(last_l)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(rdy_m), .o_sd(sd_m), .o_sv(sv_m), .o_last(last_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic v, input logic sd, input logic sdm,
                       input logic sv, input logic last, input logic rdy);
        row_t r;
        r.data = d; r.valid = v; r.sd = sd; r.sd_msb = sdm;
        r.sv = sv; r.last = last; r.rdy = rdy;
        rows.push_back(r);
    endtask

    // Drive one cycle of inputs, let one edge pass, and compare both instances.
    task automatic step(input string tag, input row_t r);
        data  = r.data;
        valid = r.valid;
        @(posedge clk);
        #1;
        chk({tag, ".sd"},       sd_l,   r.sd);
        chk({tag, ".sd_msb"},   sd_m,   r.sd_msb);
        chk({tag, ".sv"},       sv_l,   r.sv);
        chk({tag, ".sv_msb"},   sv_m,   r.sv);
        chk({tag, ".last"},     last_l, r.last);
        chk({tag, ".last_msb"}, last_m, r.last);
        chk({tag, ".ready"},    rdy_l,  r.rdy);
        chk({tag, ".rdy_msb"},  rdy_m,  r.rdy);
    endtask

    initial begin
        row_t r;

        // 0xC4, then idle: LSB 0,0,1,0,0,0,1,1 / MSB 1,1,0,0,0,1,0,0
        add(8'hC4, 1, 0, 1, 1, 0, 0);
        add(8'hC4, 0, 0, 1, 1, 0, 0);
        add(8'h00, 0, 1, 0, 1, 0, 0);
        add(8'h00, 0, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0, 1, 1, 0, 0);
        add(8'h00, 0, 1, 0, 1, 0, 0);
        add(8'h00, 0, 1, 0, 1, 1, 1);
        add(8'h00, 0, 0, 0, 0, 0, 1);
        add(8'h00, 0, 0, 0, 0, 0, 1);
        // 0xC4 then 0x3C back to back with valid held high
        add(8'hC4, 1, 0, 1, 1, 0, 0);
        add(8'h3C, 1, 0, 1, 1, 0, 0);
        add(8'h3C, 1, 1, 0, 1, 0, 0);
        add(8'h3C, 1, 0, 0, 1, 0, 0);
        add(8'h3C, 1, 0, 0, 1, 0, 0);
        add(8'h3C, 1, 0, 1, 1, 0, 0);
        add(8'h3C, 1, 1, 0, 1, 0, 0);
        add(8'h3C, 1, 1, 0, 1, 1, 1);
        add(8'h3C, 1, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0, 0, 1, 0, 0);
        add(8'h00, 0, 1, 1, 1, 0, 0);
        add(8'h00, 0, 1, 1, 1, 0, 0);
        add(8'h00, 0, 1, 1, 1, 0, 0);
        add(8'h00, 0, 1, 1, 1, 0, 0);
        add(8'h00, 0, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0, 0, 1, 1, 1);
        add(8'h00, 0, 0, 0, 0, 0, 1);
        // 0xC4 with 0xFF offered while busy: must be ignored
        add(8'hC4, 1, 0, 1, 1, 0, 0);
        add(8'hC4, 0, 0, 1, 1, 0, 0);
        add(8'hC4, 0, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 0, 0, 1, 0, 0);
        add(8'hFF, 1, 0, 0, 1, 0, 0);
        add(8'hFF, 1, 0, 1, 1, 0, 0);
        add(8'hFF, 1, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 1, 0, 1, 1, 1);
        add(8'h00, 0, 0, 0, 0, 0, 1);

        // Asynchronous reset with no clock edge yet
        rst   = 1'b0;
        data  = 8'($urandom);
        valid = 1'($urandom);
        #1;
        rst = 1'b1;
        #1;
        chk("rst.sd",    sd_l,   1'b0);
        chk("rst.sv",    sv_l,   1'b0);
        chk("rst.last",  last_l, 1'b0);
        chk("rst.ready", rdy_l,  1'b0);
        chk("rst.sv_msb", sv_m,  1'b0);
        valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel.ready", rdy_l, 1'b1);
        chk("rel.sv",    sv_l,  1'b0);

        foreach (rows[i]) step($sformatf("row%0d", i), rows[i]);

        // Reset mid-word while bit 4 of 0xC4 is on the line
        r = rows[0]; step("mr0", r);
        r = rows[1]; step("mr1", r);
        r = rows[2]; step("mr2", r);
        r = rows[3]; step("mr3", r);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.sd",    sd_l,   1'b0);
        chk("mrst.sv",    sv_l,   1'b0);
        chk("mrst.last",  last_l, 1'b0);
        chk("mrst.ready", rdy_l,  1'b0);
        chk("mrst.sv_msb", sv_m,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrel.ready", rdy_l, 1'b1);

        // 0x01 after reset: LSB 1,0,0,0,0,0,0,0 / MSB 0,...,0,1
        r = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; step("p0", r);
        for (int k = 1; k < 7; k++) begin
            r = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            step($sformatf("p%0d", k), r);
        end
        r = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}; step("p7", r);
        r = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; step("p8", r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
